// File: rtl/uart_line_tx.sv
`default_nettype none
// ============================================================================
// Module   : uart_line_tx
// Function : byte FIFO feeding an 8N1 UART transmitter, with end-of-line pulse
// Revision : 1.0 - initial release
// ============================================================================
module uart_line_tx #(
  parameter int CLK_DIV    = 16,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [7:0]                  in_data,
  input  logic                        in_valid,
  output logic                        in_ready,
  output logic                        serial_tx,
  output logic                        busy,
  output logic [$clog2(FIFO_DEPTH):0] level,
  output logic                        eol_pulse,
  output logic                        overflow
);

  localparam int ADDR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = $clog2(CLK_DIV);

  localparam logic [CNT_W-1:0]  BAUD_RELOAD = CNT_W'(CLK_DIV - 1);
  localparam logic [ADDR_W:0]   LEVEL_FULL  = (ADDR_W + 1)'(FIFO_DEPTH);
  localparam logic [ADDR_W:0]   LEVEL_ONE   = (ADDR_W + 1)'(1);
  localparam logic [ADDR_W-1:0] PTR_ONE     = ADDR_W'(1);
  localparam logic [CNT_W-1:0]  BAUD_ONE    = CNT_W'(1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  state_t            r_state;
  logic [7:0]        r_mem [FIFO_DEPTH];
  logic [ADDR_W-1:0] r_wr_ptr;
  logic [ADDR_W-1:0] r_rd_ptr;
  logic [ADDR_W:0]   r_level;
  logic              r_overflow;
  logic [CNT_W-1:0]  r_baud;
  logic [2:0]        r_bit_idx;
  logic [7:0]        r_byte;
  logic              r_tx;
  logic              r_eol;

  logic w_push;
  logic w_pop;
  logic w_bit_end;

  // Readiness looks only at the registered level, so a pop in the same
  // cycle never opens a slot for a push while full.
  assign in_ready  = !reset && (r_level != LEVEL_FULL);
  assign w_push    = in_valid && in_ready;
  assign w_pop     = (r_state == S_IDLE) && (r_level != '0);
  assign w_bit_end = (r_baud == '0);

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_level    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_ONE;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_ONE;
      end
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + LEVEL_ONE;
        2'b01:   r_level <= r_level - LEVEL_ONE;
        default: r_level <= r_level;
      endcase
      if (in_valid && !in_ready) begin
        r_overflow <= 1'b1;
      end
    end
  end

  // The baud counter counts down from CLK_DIV-1 and is reloaded on every
  // bit boundary, so each line level is held for exactly CLK_DIV cycles.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_tx      <= 1'b1;
      r_baud    <= BAUD_RELOAD;
      r_bit_idx <= '0;
      r_byte    <= '0;
      r_eol     <= 1'b0;
    end else begin
      r_eol <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_tx      <= 1'b1;
          r_baud    <= BAUD_RELOAD;
          r_bit_idx <= '0;
          if (w_pop) begin
            r_byte  <= r_mem[r_rd_ptr];
            r_tx    <= 1'b0;
            r_state <= S_START;
          end
        end
        S_START: begin
          if (w_bit_end) begin
            r_baud  <= BAUD_RELOAD;
            r_tx    <= r_byte[0];
            r_state <= S_DATA;
          end else begin
            r_baud <= r_baud - BAUD_ONE;
          end
        end
        S_DATA: begin
          if (w_bit_end) begin
            r_baud <= BAUD_RELOAD;
            if (r_bit_idx == 3'd7) begin
              r_tx    <= 1'b1;
              r_state <= S_STOP;
            end else begin
              r_bit_idx <= r_bit_idx + 3'd1;
              r_tx      <= r_byte[r_bit_idx + 3'd1];
            end
          end else begin
            r_baud <= r_baud - BAUD_ONE;
          end
        end
        S_STOP: begin
          if (w_bit_end) begin
            r_baud  <= BAUD_RELOAD;
            r_state <= S_IDLE;
            r_eol   <= (r_byte == 8'h0d) || (r_byte == 8'h0a);
          end else begin
            r_baud <= r_baud - BAUD_ONE;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_tx    <= 1'b1;
        end
      endcase
    end
  end

  assign serial_tx = r_tx;
  assign busy      = !reset && ((r_state != S_IDLE) || (r_level != '0));
  assign level     = r_level;
  assign eol_pulse = r_eol;
  assign overflow  = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_uart_line_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_line_tx
// Function : scoreboard bench for uart_line_tx with a timing-level line model
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_line_tx;

  localparam int  D     = 4;
  localparam int  DEPTH = 4;
  localparam int  FRAME = 10 * D;
  localparam int  D16   = 16;

  logic   clk = 1'b0;
  always #5 clk = ~clk;

  longint cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic                       reset, in_valid, in_ready, serial_tx, busy, eol_pulse, overflow;
  logic [7:0]                 in_data;
  logic [$clog2(DEPTH):0]     level;

  logic                       reset16, in_valid16, in_ready16, serial_tx16, busy16, eol16, ovf16;
  logic [7:0]                 in_data16;
  logic [4:0]                 level16;

  uart_line_tx #(.CLK_DIV(D), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .serial_tx(serial_tx), .busy(busy), .level(level),
    .eol_pulse(eol_pulse), .overflow(overflow)
  );

  uart_line_tx #(.CLK_DIV(D16), .FIFO_DEPTH(16)) dut16 (
    .clk(clk), .reset(reset16), .in_data(in_data16), .in_valid(in_valid16),
    .in_ready(in_ready16), .serial_tx(serial_tx16), .busy(busy16), .level(level16),
    .eol_pulse(eol16), .overflow(ovf16)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  // Each accepted byte carries the cycle it must be popped in; the frame's
  // start bit then appears one cycle later.
  typedef struct {
    logic [7:0] data;
    longint     push_cyc;
    longint     pop_cyc;
  } entry_t;

  entry_t mq[$];
  entry_t sb[$];
  longint next_free = 0;
  longint last_pop  = -1000;
  bit     ovf_m     = 1'b0;
  bit     armed     = 1'b0;

  // Called one time unit after a rising edge; drives one cycle of stimulus.
  task automatic cycle(input bit v, input logic [7:0] d, input bit r, output bit accepted);
    longint k;
    int     lvl;
    bit     rdy;
    entry_t e;
    k         = cyc;
    reset     = r;
    in_valid  = v;
    in_data   = d;
    while (mq.size() > 0 && mq[0].pop_cyc < k) begin
      last_pop = mq[0].pop_cyc;
      mq.delete(0);
    end
    lvl = mq.size();
    rdy = !r && (lvl != DEPTH);
    @(negedge clk);
    if (armed) begin
      check("level", longint'(level), longint'(lvl));
      check("overflow", longint'(overflow), longint'(ovf_m));
    end
    check("in_ready", longint'(in_ready), longint'(rdy));
    check("busy", longint'(busy), longint'(!r && (lvl > 0 || k <= last_pop + FRAME)));
    @(posedge clk);
    #1;
    accepted = 1'b0;
    if (r) begin
      mq.delete();
      sb.delete();
      ovf_m     = 1'b0;
      next_free = k + 1;
      last_pop  = -1000;
      armed     = 1'b1;
    end else if (v && rdy) begin
      e.data     = d;
      e.push_cyc = k;
      e.pop_cyc  = (next_free > k + 1) ? next_free : k + 1;
      next_free  = e.pop_cyc + FRAME + 1;
      mq.push_back(e);
      sb.push_back(e);
      accepted = 1'b1;
    end else if (v) begin
      ovf_m = 1'b1;
    end
  endtask

  task automatic idle(input int n);
    bit acc;
    for (int i = 0; i < n; i++) cycle(1'b0, 8'h00, 1'b0, acc);
  endtask

  // Line monitor: compares every line cycle against the expected waveform.
  bit     mon_in_frame = 1'b0;
  bit     mon_post_rst = 1'b0;
  entry_t mon_fb;
  int     mon_pos      = 0;
  longint mon_eol_due  = -1;

  initial begin
    longint k;
    logic   exp_b;
    forever begin
      @(negedge clk);
      k = cyc;
      if (armed) begin
        check("eol_pulse", longint'(eol_pulse), longint'(k == mon_eol_due));
        if (mon_post_rst) check("tx_after_reset", longint'(serial_tx), 1);
        mon_post_rst = 1'b0;
        if (reset) begin
          mon_in_frame = 1'b0;
          mon_eol_due  = -1;
          mon_post_rst = 1'b1;
        end else begin
          if (!mon_in_frame && sb.size() > 0 && sb[0].pop_cyc + 1 == k) begin
            mon_fb = sb.pop_front();
            mon_in_frame = 1'b1;
            mon_pos      = 0;
          end
          if (mon_in_frame) begin
            if (mon_pos < D)          exp_b = 1'b0;
            else if (mon_pos < 9 * D) exp_b = mon_fb.data[(mon_pos - D) / D];
            else                      exp_b = 1'b1;
            if (mon_pos == 0) check("frame_start", longint'(serial_tx), longint'(exp_b));
            else              check("frame_bit", longint'(serial_tx), longint'(exp_b));
            mon_pos++;
            if (mon_pos == FRAME) begin
              mon_in_frame = 1'b0;
              if (mon_fb.data == 8'h0d || mon_fb.data == 8'h0a) mon_eol_due = k + 1;
            end
          end else begin
            check("idle_line", longint'(serial_tx), 1);
          end
        end
      end
    end
  end

  // Second instance: "OK\n" at CLK_DIV=16 decoded by a mid-bit sampling receiver.
  logic [7:0] q16[$];
  bit         armed16     = 1'b0;
  longint     first_pop16 = -1;
  longint     eol16_cyc   = -1;
  int         eol16_n     = 0;
  int         rx16_n      = 0;

  initial begin
    logic [7:0] msg [3];
    msg = '{8'h4f, 8'h4b, 8'h0a};
    reset16 = 1'b1; in_valid16 = 1'b0; in_data16 = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    reset16 = 1'b0;
    armed16 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_valid16 = 1'b1;
      in_data16  = msg[i];
      q16.push_back(msg[i]);
      @(negedge clk);
      check("in_ready16", longint'(in_ready16), 1);
      @(posedge clk);
      #1;
    end
    in_valid16 = 1'b0;
  end

  initial begin
    bit         act = 1'b0;
    int         cnt = 0;
    int         idx;
    logic [7:0] sh  = 8'h00;
    forever begin
      @(negedge clk);
      if (armed16 && eol16) begin
        eol16_n++;
        eol16_cyc = cyc;
      end
      if (!armed16 || reset16) begin
        act = 1'b0;
      end else if (!act) begin
        if (serial_tx16 == 1'b0) begin
          act = 1'b1;
          cnt = 0;
          if (first_pop16 < 0) first_pop16 = cyc - 1;
        end
      end else begin
        cnt++;
        if (cnt % D16 == D16 / 2) begin
          idx = cnt / D16;
          if (idx == 0) begin
            check("rx16_start", longint'(serial_tx16), 0);
          end else if (idx <= 8) begin
            sh[idx - 1] = serial_tx16;
          end else begin
            check("rx16_stop", longint'(serial_tx16), 1);
            act = 1'b0;
            rx16_n++;
            if (q16.size() == 0) begin
              n_checks++;
              n_fail++;
              $display("FAIL rx16_byte: got unexpected byte %0h, expected none", sh);
            end else begin
              check("rx16_byte", longint'(sh), longint'(q16.pop_front()));
            end
          end
        end
      end
    end
  end

  initial begin
    bit         acc;
    longint     k0;
    logic [7:0] d;
    reset = 1'b1; in_valid = 1'b0; in_data = 8'h00;
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) cycle(1'b0, 8'h00, 1'b1, acc);

    // single frame, then back-to-back with an end-of-line byte
    cycle(1'b1, 8'hA3, 1'b0, acc);
    idle(45);
    cycle(1'b1, 8'h0d, 1'b0, acc);
    cycle(1'b1, 8'h41, 1'b0, acc);
    idle(90);

    // fill while a frame is in flight, then hold valid across the pop
    cycle(1'b1, 8'h55, 1'b0, acc);
    idle(2);
    for (int i = 0; i < 5; i++) cycle(1'b1, 8'(8'hC0 + i), 1'b0, acc);
    for (int i = 0; i < 60; i++) begin
      cycle(1'b1, 8'h66, 1'b0, acc);
      if (acc) break;
    end
    idle(220);

    // reset during data bit 3 with two bytes still queued
    k0 = cyc;
    cycle(1'b1, 8'h31, 1'b0, acc);
    cycle(1'b1, 8'h32, 1'b0, acc);
    cycle(1'b1, 8'h33, 1'b0, acc);
    while (cyc < k0 + 19) idle(1);
    cycle(1'b0, 8'h00, 1'b1, acc);
    idle(60);

    // random traffic with occasional resets
    for (int i = 0; i < 300; i++) begin
      case ($urandom_range(0, 5))
        0:       d = 8'h0a;
        1:       d = 8'h0d;
        default: d = 8'($urandom);
      endcase
      cycle($urandom_range(0, 3) == 0, d, $urandom_range(0, 149) == 0, acc);
    end
    idle(260);
    while (cyc < 700) idle(1);

    check("scoreboard_drained", longint'(sb.size()), 0);
    check("rx16_count", longint'(rx16_n), 3);
    check("eol16_count", longint'(eol16_n), 1);
    check("ok_total_time", eol16_cyc - first_pop16, 3 * (10 * D16 + 1));
    check("busy16_end", longint'(busy16), 0);
    check("level16_end", longint'(level16), 0);
    check("overflow16_end", longint'(ovf16), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/uart_line_tx.md
UART_LINE_TX -- requirements
Module: uart_line_tx

Interface
REQ-001 SHALL have parameter CLK_DIV, default 16, meaning clk cycles per UART bit period; legal range is CLK_DIV >= 2.
REQ-002 SHALL have parameter FIFO_DEPTH, default 16, meaning byte FIFO entries; legal values are powers of two >= 2.
REQ-003 SHALL have clk, input, 1 bit: the single clock; all logic is on the rising edge.
REQ-004 SHALL have reset, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have in_data, input, 8 bits: byte offered for transmission.
REQ-006 SHALL have in_valid, input, 1 bit: in_data is valid this cycle.
REQ-007 SHALL have in_ready, output, 1 bit: FIFO can accept a byte this cycle.
REQ-008 SHALL have serial_tx, output, 1 bit: 8N1 serial line, idle high, intended to drive the DUT serial_rx.
REQ-009 SHALL have busy, output, 1 bit: a frame is in progress or the FIFO is non-empty.
REQ-010 SHALL have level, output, $clog2(FIFO_DEPTH)+1 bits: current FIFO occupancy.
REQ-011 SHALL have eol_pulse, output, 1 bit: one-cycle pulse when the stop bit of a 0x0d or 0x0a frame completes.
REQ-012 SHALL have overflow, output, 1 bit: sticky flag set when a byte is offered while the FIFO is full.

Function
REQ-013 SHALL accept a byte (push) in any cycle where in_valid=1 and in_ready=1.
REQ-014 SHALL drive in_ready = (level != FIFO_DEPTH), using the registered level only; a same-cycle pop SHALL NOT permit a push when full.
REQ-015 SHALL, when in_valid=1 and in_ready=0, drop the byte, leave the FIFO unchanged, and set overflow to 1 from the next cycle until reset.
REQ-016 SHALL update level by +1 on push only, -1 on pop only, and leave it unchanged on simultaneous push and pop.
REQ-017 SHALL pop in order, one byte per frame, and SHALL NOT bypass the FIFO: a byte pushed into an empty FIFO is popped no earlier than the next cycle.
REQ-018 SHALL implement the states IDLE, START, DATA and STOP.
REQ-019 In IDLE with level > 0: SHALL pop the head byte into the shift register and go to START the next cycle; serial_tx SHALL be 1 throughout IDLE.
REQ-020 In START: SHALL drive serial_tx=0 for exactly CLK_DIV cycles, then go to DATA.
REQ-021 In DATA: SHALL send bits 0..7 LSB first, each for exactly CLK_DIV cycles, with a 3-bit bit index; after bit 7, SHALL go to STOP.
REQ-022 In STOP: SHALL drive serial_tx=1 for exactly CLK_DIV cycles, then go to IDLE.
REQ-023 SHALL produce back-to-back frames separated by exactly one IDLE cycle (the pop cycle), so each frame period is 10*CLK_DIV+1 cycles.
REQ-024 SHALL drive serial_tx from a register, so there is no combinational path from inputs to serial_tx.
REQ-025 SHALL assert eol_pulse for exactly one cycle: the first cycle after STOP ends, for frames whose byte is 0x0d or 0x0a; it SHALL be 0 otherwise.
REQ-026 SHALL keep the baud counter $clog2(CLK_DIV) bits wide, reload it at every bit boundary, and never let it wrap mid-bit.
REQ-027 SHALL NOT let pushes during a frame affect the frame in flight.

Reset
REQ-028 While reset=1: state=IDLE, serial_tx=1, level=0, in_ready=0, busy=0, eol_pulse=0, overflow=0, and the FIFO pointers are 0.
REQ-029 In the first cycle after reset deasserts, in_ready SHALL be 1.
REQ-030 Reset asserted mid-frame SHALL take effect at the next clock edge: serial_tx=1 and all queued bytes discarded; no partial frame SHALL resume.

Verification
REQ-031 CLK_DIV=4, push 0xA3 when idle: serial_tx low for 4 cycles, then bits 1,1,0,0,0,1,0,1 for 4 cycles each, then high for 4 cycles; busy=0 afterwards.
REQ-032 CLK_DIV=4, push 0x0d then 0x41 back-to-back: two frames separated by a 1-cycle idle gap; eol_pulse fires exactly once, after the first frame's stop bit.
REQ-033 FIFO_DEPTH=4 with the line stalled mid-frame: push 5 bytes on consecutive cycles -> 4 bytes accepted, level=4, in_ready=0, overflow=1; the 5th byte is never transmitted.
REQ-034 Full FIFO with in_valid held high during a pop cycle: no push in that cycle, level goes 4->3, and the push succeeds the next cycle (level back to 4).
REQ-035 Assert reset during DATA bit 3 with 2 bytes queued: serial_tx=1 the next cycle, level=0, overflow=0, and no further frames until new pushes.
REQ-036 Push the string "OK\n" with CLK_DIV=16: bytes 0x4f, 0x4b, 0x0a are decoded by a bench receiver in order; total time is 3*161 cycles from first pop to the final eol_pulse.
